hazard_ctrl: RTL and testbench

- Pipeline hazard controller for the 5-stage F-D-E-M-WB core.
- Tracks destination-register metadata of instructions in the Execute, Memory and Writeback stages in an internal shadow pipeline.
- From that state, drives the Execute-stage operand forwarding selects, load-use stalls of Fetch/Decode, bubble insertion into Execute, and flushes on taken branches resolved in Execute.
- Keeps a saturating stall-cycle counter for performance measurement.

---
 rtl/hazard_ctrl.sv | 75 +++++++
 tb/tb_hazard_ctrl.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: forwarding, load-use stall and branch flush control for the 5-stage core
// Optional feature macro: FORWARD_EN (undefined: no forwarding, stall on any E/M dependency)
module hazard_ctrl #(
  parameter int REG_ADDR_W  = 5,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   valid_D,
  input  logic [REG_ADDR_W-1:0]  rs1_D,
  input  logic [REG_ADDR_W-1:0]  rs2_D,
  input  logic                   use_rs1_D,
  input  logic                   use_rs2_D,
  input  logic [REG_ADDR_W-1:0]  rd_D,
  input  logic                   RF_WE_D,
  input  logic                   Result_D,
  input  logic                   branch_taken_E,
  output logic                   stall_F,
  output logic                   stall_D,
  output logic                   flush_D,
  output logic                   flush_E,
  output logic [1:0]             fwd_A_E,
  output logic [1:0]             fwd_B_E,
  output logic [STALL_CNT_W-1:0] stall_count
);
  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic                  we;
    logic                  is_load;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic                  use_rs1;
    logic                  use_rs2;
  } slot_t;
  slot_t e, m, w;
  logic hz_a, hz_b, hazard, unused;
  logic [1:0] fa, fb;
  function automatic logic writes(slot_t s, logic [REG_ADDR_W-1:0] r);
    return s.valid && s.we && s.rd != '0 && s.rd == r;
  endfunction
`ifdef FORWARD_EN
  assign hz_a = writes(e, rs1_D) && e.is_load;
  assign hz_b = writes(e, rs2_D) && e.is_load;
  assign fa = (e.use_rs1 && writes(m, e.rs1)) ? 2'b10 : (e.use_rs1 && writes(w, e.rs1)) ? 2'b01 : 2'b00;
  assign fb = (e.use_rs2 && writes(m, e.rs2)) ? 2'b10 : (e.use_rs2 && writes(w, e.rs2)) ? 2'b01 : 2'b00;
`else
  // W is not checked: the register file writes in the first half-cycle
  assign hz_a = writes(e, rs1_D) || writes(m, rs1_D);
  assign hz_b = writes(e, rs2_D) || writes(m, rs2_D);
  assign fa = 2'b00;
  assign fb = 2'b00;
`endif
  assign unused  = ^{e, m, w};
  assign hazard  = valid_D && ((use_rs1_D && hz_a) || (use_rs2_D && hz_b));
  assign stall_F = rst && hazard && !branch_taken_E;
  assign stall_D = stall_F;
  assign flush_D = rst && branch_taken_E;
  assign flush_E = rst && (branch_taken_E || hazard);
  assign fwd_A_E = rst ? fa : 2'b00;
  assign fwd_B_E = rst ? fb : 2'b00;
  always_ff @(posedge clk) begin
    if (!rst) begin
      e <= '0;
      m <= '0;
      w <= '0;
      stall_count <= '0;
    end else begin
      w <= m;
      m <= e;
      e <= {valid_D && !flush_E, rd_D, RF_WE_D, Result_D, rs1_D, rs2_D, use_rs1_D, use_rs2_D};
      if (stall_D && !(&stall_count)) stall_count <= stall_count + STALL_CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed checks of hazard_ctrl in either FORWARD_EN configuration
module tb_hazard_ctrl;
  localparam int AW = 5;
  localparam int CW = 4;
`ifdef FORWARD_EN
  localparam int PEN = 1;
`else
  localparam int PEN = 2;
`endif
  logic clk = 0;
  logic rst;
  logic valid_D, use_rs1_D, use_rs2_D, RF_WE_D, Result_D, branch_taken_E;
  logic [AW-1:0] rs1_D, rs2_D, rd_D;
  logic stall_F, stall_D, flush_D, flush_E;
  logic [1:0] fwd_A_E, fwd_B_E;
  logic [CW-1:0] stall_count;
  logic [7:0] ctl;
  int n_chk = 0, n_fail = 0, exp_cnt = 0;
  always #5 clk = ~clk;
  assign ctl = {stall_F, stall_D, flush_D, flush_E, fwd_A_E, fwd_B_E};
  hazard_ctrl #(.REG_ADDR_W(AW), .STALL_CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .valid_D(valid_D), .rs1_D(rs1_D), .rs2_D(rs2_D),
    .use_rs1_D(use_rs1_D), .use_rs2_D(use_rs2_D), .rd_D(rd_D), .RF_WE_D(RF_WE_D),
    .Result_D(Result_D), .branch_taken_E(branch_taken_E), .stall_F(stall_F),
    .stall_D(stall_D), .flush_D(flush_D), .flush_E(flush_E), .fwd_A_E(fwd_A_E),
    .fwd_B_E(fwd_B_E), .stall_count(stall_count)
  );
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic dec(logic v, logic [AW-1:0] rd, logic we, logic ld, logic [AW-1:0] a, logic ua, logic [AW-1:0] b, logic ub);
    valid_D = v;
    rd_D = rd;
    RF_WE_D = we;
    Result_D = ld;
    rs1_D = a;
    use_rs1_D = ua;
    rs2_D = b;
    use_rs2_D = ub;
    #1;
  endtask
  task automatic nops(int n);
    repeat (n) begin
      dec(0, 0, 0, 0, 0, 0, 0, 0);
      tick();
    end
  endtask
  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end
  initial begin
    rst = 0;
    repeat (2) begin
      valid_D = 1'($urandom); rd_D = AW'($urandom); RF_WE_D = 1'($urandom); Result_D = 1'($urandom);
      rs1_D = AW'($urandom); rs2_D = AW'($urandom); use_rs1_D = 1'($urandom); use_rs2_D = 1'($urandom);
      branch_taken_E = 1'($urandom);
      #1;
      check("rst_ctl", 32'(ctl), 0);
      tick();
      check("rst_cnt", 32'(stall_count), 0);
    end
    branch_taken_E = 0;
    rst = 1;
    nops(2);
`ifdef FORWARD_EN
    dec(1, 3, 1, 0, 1, 1, 2, 1);
    check("alu_add", 32'(ctl), 0);
    tick();
    dec(1, 4, 1, 0, 3, 1, 5, 1);
    check("alu_nostall", 32'(ctl), 0);
    tick();
    dec(1, 8, 1, 0, 3, 1, 9, 1);
    check("alu_fwdM", 32'(ctl), 8'b0000_10_00);
    tick();
    dec(0, 0, 0, 0, 0, 0, 0, 0);
    check("alu_fwdW", 32'(ctl), 8'b0000_01_00);
    tick();
    nops(2);
    dec(1, 6, 1, 1, 1, 1, 0, 0);
    tick();
    dec(1, 7, 1, 0, 6, 1, 6, 1);
    check("lu_stall", 32'(ctl), 8'b1101_00_00);
    tick();
    check("lu_release", 32'(stall_D), 0);
    check("lu_cnt", 32'(stall_count), 1);
    tick();
    dec(0, 0, 0, 0, 0, 0, 0, 0);
    check("lu_fwdW", 32'(ctl), 8'b0000_01_01);
    tick();
    exp_cnt = 1;
`else
    dec(1, 3, 1, 0, 1, 1, 2, 1);
    tick();
    dec(1, 4, 1, 0, 3, 1, 5, 1);
    check("nf_stall1", 32'(ctl), 8'b1101_00_00);
    tick();
    check("nf_stall2", 32'(ctl), 8'b1101_00_00);
    tick();
    check("nf_go", 32'(ctl), 0);
    check("nf_cnt", 32'(stall_count), 2);
    tick();
    dec(0, 0, 0, 0, 0, 0, 0, 0);
    check("nf_fwd", 32'(ctl), 0);
    tick();
    exp_cnt = 2;
`endif
    nops(2);
    dec(1, 0, 1, 1, 1, 1, 0, 0);
    tick();
    dec(1, 10, 1, 0, 0, 1, 0, 1);
    check("r0_nostall", 32'(ctl), 0);
    tick();
    dec(0, 0, 0, 0, 0, 0, 0, 0);
    check("r0_fwd", 32'(ctl), 0);
    tick();
    nops(2);
    dec(1, 11, 1, 1, 1, 1, 0, 0);
    tick();
    branch_taken_E = 1;
    dec(1, 12, 1, 0, 11, 1, 11, 1);
    check("br_flush", 32'(ctl), 8'b0011_00_00);
    tick();
    branch_taken_E = 0;
    check("br_cnt", 32'(stall_count), 32'(exp_cnt));
    nops(3);
    dec(1, 6, 1, 1, 1, 1, 0, 0);
    tick();
    dec(1, 7, 1, 0, 6, 1, 6, 1);
    check("mr_pre", 32'(stall_D), 1);
    rst = 0;
    #1;
    check("mr_ctl", 32'(ctl), 0);
    tick();
    rst = 1;
    #1;
    check("mr_post", 32'(ctl), 0);
    check("mr_cnt", 32'(stall_count), 0);
    exp_cnt = 0;
    tick();
    nops(2);
    for (int i = 0; i < 18; i++) begin
      dec(1, 6, 1, 1, 1, 1, 0, 0);
      tick();
      dec(1, 7, 1, 0, 6, 1, 0, 0);
      repeat (PEN + 1) tick();
      exp_cnt = (exp_cnt + PEN > 15) ? 15 : exp_cnt + PEN;
      check($sformatf("sat_%0d", i), 32'(stall_count), 32'(exp_cnt));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
